// File: rtl/cr_cceip_sup_dfmux_n_if.sv
// rtl/cr_cceip_sup_dfmux_n_if.sv - multi-lane stream bundle (tvalid/tlast/tdata/tstrb/tuser/tready)
// LANES=1 gives a plain single stream; lane i occupies slice [i*W +: W] of each field.
interface cr_cceip_sup_dfmux_n_if #(
   parameter int LANES  = 1,
   parameter int DATA_W = 64,
   parameter int USER_W = 8
);
   logic [LANES-1:0]          tvalid;
   logic [LANES-1:0]          tlast;
   logic [LANES*DATA_W-1:0]   tdata;
   logic [LANES*DATA_W/8-1:0] tstrb;
   logic [LANES*USER_W-1:0]   tuser;
   logic [LANES-1:0]          tready;

   modport master (output tvalid, tlast, tdata, tstrb, tuser, input tready);
   modport slave  (input tvalid, tlast, tdata, tstrb, tuser, output tready);
endinterface

// File: rtl/cr_cceip_sup_dfmux_n.sv
// rtl/cr_cceip_sup_dfmux_n.sv - N-channel packet-safe stream mux, command counters, interrupt summary, idle
// Define CR_CCEIP_SUP_DFMUX_OREG_EN to register the outbound stream through a 2-entry skid buffer.
module cr_cceip_sup_dfmux_n #(
   parameter int NUM_CH    = 2,
   parameter int SEL_W     = 3,
   parameter int DATA_W    = 64,
   parameter int USER_W    = 8,
   parameter int CNT_W     = 8,
   parameter int NUM_INT   = 2,
   parameter int IDLE_HOLD = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cr_cceip_sup_dfmux_n_if.slave  ib,
   input  logic [NUM_CH-1:0]     ch_qual,
   input  logic [SEL_W-1:0]      df_mux_sel,
   cr_cceip_sup_dfmux_n_if.master ob,
   input  logic                  isf_rqe_rx,
   input  logic                  isf_cqe_rx,
   input  logic                  isf_cqe_exit,
   input  logic                  osf_cqe_exit,
   input  logic                  cnt_err_clr,
   input  logic [NUM_INT-1:0]    int_in,
   input  logic [NUM_INT-1:0]    int_mask,
   output logic                  cceip_int,
   output logic                  sup_osf_halt,
   output logic                  cceip_idle,
   output logic [CNT_W-1:0]      isf_cmds,
   output logic [CNT_W-1:0]      pipe_cmds,
   output logic [CNT_W-1:0]      cqe_cmds,
   output logic                  isf_busy,
   output logic                  data_busy,
   output logic                  comp_busy,
   output logic [5:0]            cnt_err
);
   localparam int STRB_W = DATA_W / 8;
   localparam int IW     = $clog2(IDLE_HOLD + 1);

   logic [SEL_W-1:0]  act_sel;
   logic              in_pkt;
   logic              down_rdy;
   logic              acc;
   logic              mux_valid;
   logic              mux_last;
   logic [DATA_W-1:0] mux_data;
   logic [STRB_W-1:0] mux_strb;
   logic [USER_W-1:0] mux_user;

   always_comb begin
      mux_valid = 1'b0;
      mux_last  = 1'b0;
      mux_data  = '0;
      mux_strb  = '0;
      mux_user  = '0;
      ib.tready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (act_sel == SEL_W'(i)) begin
            mux_valid    = ib.tvalid[i] & ch_qual[i];
            mux_last     = ib.tlast[i];
            mux_data     = ib.tdata[i*DATA_W +: DATA_W];
            mux_strb     = ib.tstrb[i*STRB_W +: STRB_W];
            mux_user     = ib.tuser[i*USER_W +: USER_W];
            ib.tready[i] = down_rdy & ch_qual[i];
         end
      end
   end

   assign acc = mux_valid & down_rdy;

`ifdef CR_CCEIP_SUP_DFMUX_OREG_EN
   localparam int ENT_W = 1 + DATA_W + STRB_W + USER_W;

   logic [ENT_W-1:0] skid_mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       skid_cnt;
   logic             pop;

   assign down_rdy = (skid_cnt != 2'd2);
   assign pop      = (skid_cnt != 2'd0) & ob.tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_mem[0] <= '0;
         skid_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         skid_cnt    <= 2'd0;
      end else begin
         if (acc) begin
            skid_mem[wr_ptr] <= {mux_last, mux_data, mux_strb, mux_user};
            wr_ptr           <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         skid_cnt <= skid_cnt + {1'b0, acc} - {1'b0, pop};
      end
   end

   assign ob.tvalid = (skid_cnt != 2'd0);
   assign {ob.tlast, ob.tdata, ob.tstrb, ob.tuser} = skid_mem[rd_ptr];
`else
   assign down_rdy  = ob.tready;
   assign ob.tvalid = mux_valid;
   assign ob.tlast  = mux_last;
   assign ob.tdata  = mux_data;
   assign ob.tstrb  = mux_strb;
   assign ob.tuser  = mux_user;
`endif

   // The tlast edge also reloads the select so a queued change takes effect on the very next beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_sel <= '0;
         in_pkt  <= 1'b0;
      end else begin
         if (!in_pkt || (acc && mux_last))
            act_sel <= df_mux_sel;
         if (acc)
            in_pkt <= ~mux_last;
      end
   end

   // Returns {udf, ovf, next}; simultaneous inc and dec cancel.
   function automatic logic [CNT_W+1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic dec);
      logic             ovf;
      logic             udf;
      logic [CNT_W-1:0] nxt;
      ovf = 1'b0;
      udf = 1'b0;
      nxt = cnt;
      if (inc && !dec) begin
         if (&cnt) ovf = 1'b1;
         else      nxt = cnt + CNT_W'(1);
      end else if (dec && !inc) begin
         if (cnt == '0) udf = 1'b1;
         else           nxt = cnt - CNT_W'(1);
      end
      return {udf, ovf, nxt};
   endfunction

   logic [CNT_W+1:0] isf_s;
   logic [CNT_W+1:0] pipe_s;
   logic [CNT_W+1:0] cqe_s;
   logic [5:0]       new_err;
   logic             quiet;
   logic [IW-1:0]    idle_cnt;

   assign isf_s   = cnt_step(isf_cmds,  isf_rqe_rx, isf_cqe_exit);
   assign pipe_s  = cnt_step(pipe_cmds, isf_rqe_rx, osf_cqe_exit);
   assign cqe_s   = cnt_step(cqe_cmds,  isf_cqe_rx, osf_cqe_exit);
   assign new_err = {cqe_s[CNT_W+1:CNT_W], pipe_s[CNT_W+1:CNT_W], isf_s[CNT_W+1:CNT_W]};

   assign isf_busy  = (isf_cmds  != '0);
   assign data_busy = (pipe_cmds != '0);
   assign comp_busy = (cqe_cmds  != '0);
   assign quiet     = (pipe_cmds == '0) && (isf_cmds == '0) && !in_pkt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isf_cmds     <= '0;
         pipe_cmds    <= '0;
         cqe_cmds     <= '0;
         cnt_err      <= '0;
         cceip_int    <= 1'b0;
         sup_osf_halt <= 1'b0;
         idle_cnt     <= '0;
         cceip_idle   <= 1'b0;
      end else begin
         isf_cmds     <= isf_s[CNT_W-1:0];
         pipe_cmds    <= pipe_s[CNT_W-1:0];
         cqe_cmds     <= cqe_s[CNT_W-1:0];
         cnt_err      <= (cnt_err_clr ? 6'b0 : cnt_err) | new_err;
         cceip_int    <= |(int_in & ~int_mask);
         sup_osf_halt <= |int_in;
         if (quiet) begin
            if (idle_cnt != IW'(IDLE_HOLD))
               idle_cnt <= idle_cnt + IW'(1);
            cceip_idle <= (idle_cnt == IW'(IDLE_HOLD - 1)) || (idle_cnt == IW'(IDLE_HOLD));
         end else begin
            idle_cnt   <= '0;
            cceip_idle <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_cr_cceip_sup_dfmux_n.sv
// tb/tb_cr_cceip_sup_dfmux_n.sv - directed self-checking bench for cr_cceip_sup_dfmux_n (NUM_CH=4)
module tb_cr_cceip_sup_dfmux_n;
   localparam int NUM_CH    = 4;
   localparam int SEL_W     = 3;
   localparam int DATA_W    = 64;
   localparam int USER_W    = 8;
   localparam int CNT_W     = 8;
   localparam int NUM_INT   = 2;
   localparam int IDLE_HOLD = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cr_cceip_sup_dfmux_n_if #(.LANES(NUM_CH), .DATA_W(DATA_W), .USER_W(USER_W)) ib ();
   cr_cceip_sup_dfmux_n_if #(.LANES(1),      .DATA_W(DATA_W), .USER_W(USER_W)) ob ();

   logic [NUM_CH-1:0]  ch_qual;
   logic [SEL_W-1:0]   df_mux_sel;
   logic               isf_rqe_rx, isf_cqe_rx, isf_cqe_exit, osf_cqe_exit, cnt_err_clr;
   logic [NUM_INT-1:0] int_in, int_mask;
   logic               cceip_int, sup_osf_halt, cceip_idle;
   logic [CNT_W-1:0]   isf_cmds, pipe_cmds, cqe_cmds;
   logic               isf_busy, data_busy, comp_busy;
   logic [5:0]         cnt_err;

   int checks   = 0;
   int failures = 0;

   cr_cceip_sup_dfmux_n #(
      .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DATA_W(DATA_W), .USER_W(USER_W),
      .CNT_W(CNT_W), .NUM_INT(NUM_INT), .IDLE_HOLD(IDLE_HOLD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ib(ib), .ch_qual(ch_qual), .df_mux_sel(df_mux_sel), .ob(ob),
      .isf_rqe_rx(isf_rqe_rx), .isf_cqe_rx(isf_cqe_rx), .isf_cqe_exit(isf_cqe_exit),
      .osf_cqe_exit(osf_cqe_exit), .cnt_err_clr(cnt_err_clr), .int_in(int_in), .int_mask(int_mask),
      .cceip_int(cceip_int), .sup_osf_halt(sup_osf_halt), .cceip_idle(cceip_idle),
      .isf_cmds(isf_cmds), .pipe_cmds(pipe_cmds), .cqe_cmds(cqe_cmds),
      .isf_busy(isf_busy), .data_busy(data_busy), .comp_busy(comp_busy), .cnt_err(cnt_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // tstrb follows the low data byte so each beat carries a distinct strobe too
   task automatic drive_ch(input int ch, input logic v, input logic last,
                           input logic [63:0] d, input logic [7:0] u);
      ib.tvalid[ch]            = v;
      ib.tlast[ch]             = last;
      ib.tdata[ch*DATA_W +: DATA_W] = d;
      ib.tstrb[ch*8 +: 8]      = d[7:0];
      ib.tuser[ch*USER_W +: USER_W] = u;
   endtask

   initial begin
      rst_n = 1'b0;
      ib.tvalid = '0; ib.tlast = '0; ib.tdata = '0; ib.tstrb = '0; ib.tuser = '0;
      ob.tready = 1'b0; ch_qual = '0; df_mux_sel = '0;
      isf_rqe_rx = 0; isf_cqe_rx = 0; isf_cqe_exit = 0; osf_cqe_exit = 0; cnt_err_clr = 0;
      int_in = '0; int_mask = '0;
      repeat (3) tick();
      chk("rst_ob_tvalid", ob.tvalid, 0);
      chk("rst_ib_tready", ib.tready, 0);
      chk("rst_ob_tdata", ob.tdata, 0);
      chk("rst_counts", {isf_cmds, pipe_cmds, cqe_cmds}, 0);
      chk("rst_cnt_err", cnt_err, 0);
      chk("rst_flags", {cceip_int, sup_osf_halt, cceip_idle, isf_busy, data_busy, comp_busy}, 0);
      rst_n = 1'b1;

      // 3-beat packet on ch2, select moves to ch1 after the first beat
      df_mux_sel = 3'd2; ch_qual = 4'hF; ob.tready = 1'b1;
      tick();
      drive_ch(2, 1, 0, 64'hA1, 8'h11);
      drive_ch(1, 1, 1, 64'hB1, 8'h22);
      #1;
      chk("b1_valid", ob.tvalid, 1);
      chk("b1_data", ob.tdata, 64'hA1);
      chk("b1_user", ob.tuser, 8'h11);
      chk("b1_last", ob.tlast, 0);
      chk("b1_ready", ib.tready, 4'b0100);
      tick();
      df_mux_sel = 3'd1;
      drive_ch(2, 1, 0, 64'hA2, 8'h12);
      #1;
      chk("b2_data", ob.tdata, 64'hA2);
      chk("b2_ready", ib.tready, 4'b0100);
      tick();
      drive_ch(2, 1, 1, 64'hA3, 8'h13);
      #1;
      chk("b3_data", ob.tdata, 64'hA3);
      chk("b3_last", ob.tlast, 1);
      chk("b3_strb", ob.tstrb, 8'hA3);
      tick();
      drive_ch(2, 0, 0, 64'h0, 8'h0);
      #1;
      chk("sw_valid", ob.tvalid, 1);
      chk("sw_data", ob.tdata, 64'hB1);
      chk("sw_ready", ib.tready, 4'b0010);
      ch_qual = 4'b1101;
      #1;
      chk("qual_valid", ob.tvalid, 0);
      chk("qual_ready", ib.tready, 0);
      ch_qual = 4'hF; ob.tready = 1'b0;
      #1;
      chk("bp_ready", ib.tready, 0);
      chk("bp_valid", ob.tvalid, 1);
      ob.tready = 1'b1; df_mux_sel = 3'd5;
      tick();
      for (int i = 0; i < NUM_CH; i++) drive_ch(i, 1, 1, 64'hF0 + 64'(i), 8'h33);
      #1;
      chk("oor_valid", ob.tvalid, 0);
      chk("oor_ready", ib.tready, 0);
      chk("oor_data", ob.tdata, 0);
      ib.tvalid = '0;

      // counters: hold on simultaneous inc/dec, underflow, clear
      isf_rqe_rx = 1;
      repeat (5) tick();
      isf_rqe_rx = 0;
      chk("pipe_five", pipe_cmds, 5);
      isf_rqe_rx = 1; osf_cqe_exit = 1;
      tick();
      isf_rqe_rx = 0; osf_cqe_exit = 0;
      chk("pipe_hold", pipe_cmds, 5);
      chk("isf_inc", isf_cmds, 6);
      chk("cqe_udf_hold", cqe_cmds, 0);
      chk("cqe_udf_flag", cnt_err, 6'b100000);
      chk("busy_bits", {isf_busy, data_busy, comp_busy}, 3'b110);
      cnt_err_clr = 1;
      tick();
      cnt_err_clr = 0;
      chk("err_clr", cnt_err, 0);

      // interrupt summary and halt
      int_in = 2'b10; int_mask = 2'b10;
      tick();
      chk("int_masked", cceip_int, 0);
      chk("halt_unmasked", sup_osf_halt, 1);
      int_mask = 2'b00;
      tick();
      chk("int_unmasked", cceip_int, 1);

      // reset in the middle of a ch0 packet
      df_mux_sel = 3'd0;
      tick();
      drive_ch(0, 1, 0, 64'hC0, 8'h44);
      #1;
      chk("mid_data", ob.tdata, 64'hC0);
      tick();
      rst_n = 1'b0;
      drive_ch(0, 0, 0, 64'h0, 8'h0);
      #1;
      chk("mrst_counts", {isf_cmds, pipe_cmds, cqe_cmds}, 0);
      chk("mrst_flags", {cceip_int, sup_osf_halt, cceip_idle, cnt_err}, 0);
      int_in = '0;
      tick();
      rst_n = 1'b1;
      df_mux_sel = 3'd3;
      drive_ch(3, 1, 1, 64'hC3, 8'h55);
      tick();
      chk("mrst_newsel", ob.tdata, 64'hC3);
      drive_ch(3, 0, 0, 64'h0, 8'h0);

      // idle rises IDLE_HOLD cycles after pipe_cmds returns to 0
      isf_rqe_rx = 1;
      tick();
      isf_rqe_rx = 0; isf_cqe_exit = 1;
      tick();
      isf_cqe_exit = 0;
      chk("idle_busy", cceip_idle, 0);
      osf_cqe_exit = 1;
      tick();
      osf_cqe_exit = 0;
      chk("idle_pipe0", pipe_cmds, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("idle_wait", cceip_idle, 0);
      end
      tick();
      chk("idle_rise", cceip_idle, 1);

      // a command arriving two cycles into a window restarts it
      isf_rqe_rx = 1;
      tick();
      isf_rqe_rx = 0; isf_cqe_exit = 1; osf_cqe_exit = 1;
      tick();
      isf_cqe_exit = 0; osf_cqe_exit = 0;
      chk("win_a0", cceip_idle, 0);
      repeat (2) tick();
      isf_rqe_rx = 1;
      tick();
      isf_rqe_rx = 0; isf_cqe_exit = 1; osf_cqe_exit = 1;
      chk("win_a3", cceip_idle, 0);
      tick();
      isf_cqe_exit = 0; osf_cqe_exit = 0;
      chk("win_a4", cceip_idle, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("win_b_wait", cceip_idle, 0);
      end
      tick();
      chk("win_b_rise", cceip_idle, 1);

      // saturation at all-ones, and a new error beating a same-cycle clear
      cnt_err_clr = 1;
      tick();
      cnt_err_clr = 0;
      isf_rqe_rx = 1;
      repeat (255) tick();
      chk("sat_255", pipe_cmds, 255);
      chk("sat_no_err", cnt_err, 0);
      tick();
      chk("sat_hold", pipe_cmds, 255);
      chk("sat_ovf", cnt_err, 6'b000101);
      cnt_err_clr = 1;
      tick();
      chk("clr_vs_new", cnt_err, 6'b000101);
      isf_rqe_rx = 0;
      tick();
      cnt_err_clr = 0;
      chk("clr_final", cnt_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cr_cceip_sup_dfmux_n.md
Name: cr_cceip_sup_dfmux_n

Overview:
Parametrised successor to the CCEIP support core. It is an N-channel AXI4-stream data-flow mux with a packet-boundary-safe channel switch. It also tracks commands in the pipeline with saturating counters and sticky error flags, aggregates masked interrupts, and generates a debounced idle. It sits in the cceip support wrapper, between the per-engine CRC checker/generator outputs and the downstream data-flow consumer.

Parameters:
NUM_CH, 2, number of inbound stream channels (2..8)
SEL_W, 3, width of channel select (must satisfy 2**SEL_W >= NUM_CH)
DATA_W, 64, tdata width
USER_W, 8, tuser width (tstrb width = DATA_W/8)
CNT_W, 8, width of each command counter
NUM_INT, 2, number of interrupt sources
IDLE_HOLD, 4, consecutive quiet cycles required before idle asserts (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ib_tvalid  in  NUM_CH  per-channel tvalid
ib_tlast  in  NUM_CH  per-channel tlast
ib_tdata  in  NUM_CH*DATA_W  per-channel tdata; channel i is at [i*DATA_W +: DATA_W]
ib_tstrb  in  NUM_CH*DATA_W/8  per-channel tstrb
ib_tuser  in  NUM_CH*USER_W  per-channel tuser
ib_tready  out  NUM_CH  per-channel tready
ch_qual  in  NUM_CH  per-channel side-path ready; gates the channel's valid and ready
df_mux_sel  in  SEL_W  requested channel (CSR)
ob_tvalid/ob_tlast/ob_tdata/ob_tstrb/ob_tuser  out  1/1/DATA_W/DATA_W/8/USER_W  muxed stream
ob_tready  in  1  downstream ready
isf_rqe_rx, isf_cqe_rx, isf_cqe_exit, osf_cqe_exit  in  1 each  command event pulses
cnt_err_clr  in  1  clears sticky counter error bits
int_in  in  NUM_INT  raw interrupt sources
int_mask  in  NUM_INT  1 = masked
cceip_int  out  1  masked interrupt summary
sup_osf_halt  out  1  OSF halt request
cceip_idle  out  1  debounced idle
isf_cmds, pipe_cmds, cqe_cmds  out  CNT_W each  counter values
isf_busy, data_busy, comp_busy  out  1 each  counter != 0
cnt_err  out  6  sticky flags {cqe_udf, cqe_ovf, pipe_udf, pipe_ovf, isf_udf, isf_ovf}

Behaviour:
- Reset: all outputs 0. act_sel=0, in_pkt=0, all counters 0, idle_cnt=0, cceip_idle=0.
- act_sel register: loads df_mux_sel on any cycle where in_pkt=0. A select change during a packet is ignored until the cycle after the tlast beat is accepted.
- Datapath is combinational (0 latency) for act_sel = a < NUM_CH:
  - ob_tvalid = ib_tvalid[a] & ch_qual[a]
  - ob_tlast/tdata/tstrb/tuser = channel a fields
  - ib_tready[a] = ob_tready & ch_qual[a]
  - all other ib_tready = 0 (backpressure; no drop)
- act_sel >= NUM_CH: ob_tvalid=0, all ib_tready=0, data outputs 0.
- acc = ob_tvalid & ob_tready.
  - acc & !tlast: in_pkt <= 1
  - acc & tlast: in_pkt <= 0
- Counters (isf: inc isf_rqe_rx, dec isf_cqe_exit; pipe: inc isf_rqe_rx, dec osf_cqe_exit; cqe: inc isf_cqe_rx, dec osf_cqe_exit):
  - inc only: +1; dec only: -1; both or neither: hold.
  - inc at all-ones: hold at max and set the matching ovf bit.
  - dec at 0: hold at 0 and set the matching udf bit.
  - cnt_err_clr clears all bits. A new error in the same cycle as cnt_err_clr wins (bit = 1).
- busy outputs are combinational from the counters.
- cceip_int <= |(int_in & ~int_mask), 1-cycle latency.
- sup_osf_halt <= |int_in (mask ignored), 1-cycle latency.
- Idle:
  - quiet = (pipe_cmds==0) & (isf_cmds==0) & !in_pkt
  - quiet: idle_cnt increments, saturating at IDLE_HOLD
  - !quiet: idle_cnt <= 0 and cceip_idle <= 0 in the same edge
  - cceip_idle <= (idle_cnt == IDLE_HOLD-1) | (idle_cnt == IDLE_HOLD) while quiet; it rises IDLE_HOLD cycles after quiet begins.
- Reset asserted mid-packet: all state clears asynchronously; the next packet is taken from the df_mux_sel sampled after reset.

Optional Feature:
CR_CCEIP_SUP_DFMUX_OREG_EN
- Defined: a 2-entry skid buffer registers the ob_* outputs.
  - Latency +1 cycle.
  - ib_tready = !skid_full & ch_qual[a].
  - Throughput of 1 beat/cycle is kept under continuous ob_tready.
  - in_pkt and acc are computed at the buffer input.
  - The buffer resets empty.
- Not defined: combinational path as described in Behaviour.

Test Plan:
- NUM_CH=4, sel=2, 3-beat packet on ch2 with ch_qual=1 and ob_tready=1 → 3 beats out, tlast on beat 3; ib_tready = 4'b0100.
- sel changes 2→1 after beat 1 of a 3-beat ch2 packet → beats 2–3 still come from ch2; the first ch1 beat appears the cycle after ch2's tlast is accepted.
- isf_rqe_rx and osf_cqe_exit pulse together with pipe_cmds=5 → pipe_cmds stays 5. Drive 256 inc pulses from 0 (CNT_W=8) → pipe_cmds=255 and pipe_ovf=1. Then cnt_err_clr → cnt_err=0.
- osf_cqe_exit with cqe_cmds=0 → cqe_cmds stays 0 and cqe_udf=1.
- int_in=2'b10, int_mask=2'b10 → cceip_int=0 and sup_osf_halt=1 one cycle later. Then mask=0 → cceip_int=1.
- IDLE_HOLD=4, pipe_cmds goes 1→0 → cceip_idle rises 4 cycles later. An isf_rqe_rx pulse 2 cycles into that window → idle stays 0 and the window restarts. Reset mid-packet → all outputs 0 and in_pkt=0.
